// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: port indices, one-hot request codes and controller state encoding shared with switch_fabric
package switch_allocator_pkg;
    localparam int PORTS = 5;
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;
    localparam int PORT_C = 2;
    localparam int PORT_D = 3;
    localparam int PORT_E = 4;
    localparam logic [4:0] RQS0 = 5'b00001;
    localparam logic [4:0] RQS1 = 5'b00010;
    localparam logic [4:0] RQS2 = 5'b00100;
    localparam logic [4:0] RQS3 = 5'b01000;
    localparam logic [4:0] RQS4 = 5'b10000;
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;
    function automatic logic [4:0] onehot(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction
endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: one output port controller, round-robin grant held until the owner's transfer completes
//   req   candidate inputs (already masked), done = granted input finished, grant = registered one-hot owner
module rr_arbiter
    import switch_allocator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic       done,
    output logic [4:0] grant
);
    logic       state;
    logic [2:0] ptr;
    logic [2:0] win;
    logic [3:0] k;
    // walk from the farthest slot back to ptr so the nearest candidate is the last one kept
    always_comb begin
        win = ptr;
        k = '0;
        for (int j = PORTS - 1; j >= 0; j--) begin
            k = {1'b0, ptr} + 4'(j);
            k = (k >= 4'd5) ? k - 4'd5 : k;
            win = req[k[2:0]] ? k[2:0] : win;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            grant <= '0;
        end else if (state == IDLE && |req) begin
            state <= BUSY;
            grant <= onehot(win);
            ptr <= (win == 3'd4) ? 3'd0 : win + 3'd1;
        end else if (state == BUSY && done) begin
            state <= IDLE;
            grant <= '0;
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin allocation of a 5-port router crossbar
//   req_vecX one-hot wanted output, xfer_doneX release pulse, sf_cfg_vecX fabric mux select, grant_vecX granted output
module switch_allocator
    import switch_allocator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req_vecA,
    input  logic [4:0] req_vecB,
    input  logic [4:0] req_vecC,
    input  logic [4:0] req_vecD,
    input  logic [4:0] req_vecE,
    input  logic       xfer_doneA,
    input  logic       xfer_doneB,
    input  logic       xfer_doneC,
    input  logic       xfer_doneD,
    input  logic       xfer_doneE,
    output logic [4:0] sf_cfg_vecA,
    output logic [4:0] sf_cfg_vecB,
    output logic [4:0] sf_cfg_vecC,
    output logic [4:0] sf_cfg_vecD,
    output logic [4:0] sf_cfg_vecE,
    output logic [4:0] grant_vecA,
    output logic [4:0] grant_vecB,
    output logic [4:0] grant_vecC,
    output logic [4:0] grant_vecD,
    output logic [4:0] grant_vecE
);
    localparam logic [4:0] RQS [PORTS] = '{RQS0, RQS1, RQS2, RQS3, RQS4};
    logic [4:0] req [PORTS];
    logic [4:0] cfg [PORTS];
    logic [4:0] gnt [PORTS];
    logic [4:0] xfer_done;
    assign req[PORT_A] = req_vecA;
    assign req[PORT_B] = req_vecB;
    assign req[PORT_C] = req_vecC;
    assign req[PORT_D] = req_vecD;
    assign req[PORT_E] = req_vecE;
    assign xfer_done = {xfer_doneE, xfer_doneD, xfer_doneC, xfer_doneB, xfer_doneA};
    genvar o, i;
    for (o = 0; o < PORTS; o++) begin : g_out
        logic [4:0] cand;
        // exact one-hot match drops multi-bit requests; inputs already holding a grant are not candidates
        for (i = 0; i < PORTS; i++) begin : g_in
            assign cand[i] = (req[i] == RQS[o]) && (gnt[i] == '0);
        end
        rr_arbiter u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (cand),
            .done  (|(cfg[o] & xfer_done)),
            .grant (cfg[o])
        );
    end
    always_comb begin
        for (int a = 0; a < PORTS; a++) begin
            gnt[a] = '0;
            for (int b = 0; b < PORTS; b++) gnt[a][b] = cfg[b][a];
        end
    end
    assign sf_cfg_vecA = cfg[PORT_A];
    assign sf_cfg_vecB = cfg[PORT_B];
    assign sf_cfg_vecC = cfg[PORT_C];
    assign sf_cfg_vecD = cfg[PORT_D];
    assign sf_cfg_vecE = cfg[PORT_E];
    assign grant_vecA = gnt[PORT_A];
    assign grant_vecB = gnt[PORT_B];
    assign grant_vecC = gnt[PORT_C];
    assign grant_vecD = gnt[PORT_D];
    assign grant_vecE = gnt[PORT_E];
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vector table plus randomized run against an ownership model
module tb_switch_allocator;
    typedef struct packed {
        logic        r;
        logic [24:0] q;
        logic [4:0]  d;
        logic [24:0] e;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] rq [5];
    logic [4:0] dn = '0;
    logic [4:0] cfg [5];
    logic [4:0] gv [5];
    int checks = 0;
    int errors = 0;
    int own [5];
    int ptr [5];
    vec_t tv [$];
    always #5 clk = ~clk;
    switch_allocator dut (
        .clk(clk), .reset(reset),
        .req_vecA(rq[0]), .req_vecB(rq[1]), .req_vecC(rq[2]), .req_vecD(rq[3]), .req_vecE(rq[4]),
        .xfer_doneA(dn[0]), .xfer_doneB(dn[1]), .xfer_doneC(dn[2]), .xfer_doneD(dn[3]), .xfer_doneE(dn[4]),
        .sf_cfg_vecA(cfg[0]), .sf_cfg_vecB(cfg[1]), .sf_cfg_vecC(cfg[2]), .sf_cfg_vecD(cfg[3]), .sf_cfg_vecE(cfg[4]),
        .grant_vecA(gv[0]), .grant_vecB(gv[1]), .grant_vecC(gv[2]), .grant_vecD(gv[3]), .grant_vecE(gv[4])
    );
    function automatic vec_t mk(input logic r, input logic [4:0] a, b, c, d, e, input logic [4:0] dd,
                                input logic [4:0] xa, xb, xc, xd, xe);
        return '{r: r, q: {e, d, c, b, a}, d: dd, e: {xe, xd, xc, xb, xa}};
    endfunction
    task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
        end
    endtask
    // each output either has an owner input or is free; a free output takes the first
    // requester at or after its pointer that wants exactly it and owns nothing yet
    task automatic model_step();
        int nown [5];
        bit held;
        int k;
        if (reset) begin
            for (int o = 0; o < 5; o++) begin
                own[o] = -1;
                ptr[o] = 0;
            end
            return;
        end
        for (int o = 0; o < 5; o++) begin
            nown[o] = own[o];
            if (own[o] >= 0) begin
                if (dn[own[o]]) nown[o] = -1;
            end else begin
                for (int j = 0; j < 5; j++) begin
                    k = (ptr[o] + j) % 5;
                    held = 0;
                    for (int p = 0; p < 5; p++) if (own[p] == k) held = 1;
                    if (rq[k] == 5'(1 << o) && !held) begin
                        nown[o] = k;
                        ptr[o] = (k + 1) % 5;
                        break;
                    end
                end
            end
        end
        for (int o = 0; o < 5; o++) own[o] = nown[o];
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic check_model();
        logic [4:0] e;
        for (int o = 0; o < 5; o++) chk("model_sf_cfg", o, cfg[o], own[o] >= 0 ? 5'(1 << own[o]) : 5'd0);
        for (int i = 0; i < 5; i++) begin
            e = '0;
            for (int o = 0; o < 5; o++) if (own[o] == i) e[o] = 1'b1;
            chk("model_grant", i, gv[i], e);
        end
    endtask
    initial begin
        logic [4:0] eg;
        logic [4:0] v;
        for (int i = 0; i < 5; i++) begin
            rq[i] = '0;
            own[i] = -1;
            ptr[i] = 0;
        end
        //          r  A        B        C        D        E        done     cfgA     cfgB     cfgC     cfgD     cfgE
        tv.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00101, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00010, 5'b00001, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b00000, 5'b10000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 5'b00000, 5'b10000));
        tv.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        tv.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
        #2;
        foreach (tv[n]) begin
            reset = tv[n].r;
            dn = tv[n].d;
            for (int i = 0; i < 5; i++) rq[i] = tv[n].q[5*i +: 5];
            tick();
            for (int o = 0; o < 5; o++) chk("vec_sf_cfg", n * 10 + o, cfg[o], tv[n].e[5*o +: 5]);
            for (int i = 0; i < 5; i++) begin
                for (int o = 0; o < 5; o++) eg[o] = tv[n].e[5*o + i];
                chk("vec_grant", n * 10 + i, gv[i], eg);
            end
            check_model();
        end
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = 5'($urandom_range(0, 9));
                    if (v < 5'd3) rq[i] = '0;
                    else if (v < 5'd9) rq[i] = 5'(1 << $urandom_range(0, 4));
                    else begin
                        v = 5'($urandom_range(0, 31));
                        rq[i] = ($countones(v) < 2) ? (v | 5'b00011) & ~5'b00100 : v;
                    end
                end
                dn[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
            check_model();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
